// File: rtl/ex_pipe_reg_pkg.sv
// ex_pipe_reg_pkg: shared definitions for the decode-to-execute pipeline register.
//   - default bundle widths (control, data, register tags)
//   - bit offsets of the fields inside the control bundle
package ex_pipe_reg_pkg;

    localparam int unsigned CTRL_W_DEF = 9;
    localparam int unsigned DATA_W_DEF = 96;
    localparam int unsigned TAG_W_DEF  = 15;

    // Control bundle layout, msb first:
    // {regwrite, memtoreg, memwrite, alusrc, regdst, alucontrol[2:0], branch}
    localparam int unsigned REGWRITE    = 8;
    localparam int unsigned MEMTOREG    = 7;
    localparam int unsigned MEMWRITE    = 6;
    localparam int unsigned ALUSRC      = 5;
    localparam int unsigned REGDST      = 4;
    localparam int unsigned ALUCTRL_MSB = 3;
    localparam int unsigned ALUCTRL_LSB = 1;
    localparam int unsigned BRANCH      = 0;

endpackage

// File: rtl/ex_pipe_reg_entry.sv
// pipe_entry: one valid + payload slot.
//   clk, rst_n : clock, asynchronous active-low reset (slot empty, payload 0)
//   clear      : synchronous flush; empties the slot and zeroes the payload
//   load       : capture d and mark valid
//   drop       : mark invalid, payload holds its last value
//   d          : payload in
//   valid, q   : slot state
module pipe_entry
    import ex_pipe_reg_pkg::*;
#(
    parameter int unsigned W = CTRL_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic         drop,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_pipe_reg.sv
// ex_pipe_reg: decode-to-execute pipeline register with valid/ready flow control.
//   clk, rst_n        : clock, asynchronous active-low reset
//   valid_i, ready_o  : decode-side handshake
//   ctrl_i/data_i/tag_i : control, data and register-tag bundles in
//   flush_i           : discard held and incoming beats (highest priority)
//   valid_o, ready_i  : execute-side handshake
//   ctrl_o/data_o/tag_o : bundles out; ctrl_o reads 0 when no beat is valid
//   flush_cnt_o       : saturating count of flushes that discarded something
// SKID=1 adds a second entry so ready_o comes straight from a flop.
module ex_pipe_reg
    import ex_pipe_reg_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam int unsigned PW = CTRL_W + DATA_W + TAG_W;

    logic [PW-1:0]     in_pl;
    logic [PW-1:0]     m_d;
    logic [PW-1:0]     m_q;
    logic              m_valid;
    logic              m_load;
    logic              m_drop;
    logic              accept;
    logic              issue;
    logic              held;
    logic [CTRL_W-1:0] m_ctrl;
    logic [CNT_W-1:0]  cnt;

    assign in_pl  = {ctrl_i, data_i, tag_i};
    assign accept = valid_i & ready_o;
    assign issue  = m_valid & ready_i;

    pipe_entry #(.W(PW)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush_i),
        .load  (m_load),
        .drop  (m_drop),
        .d     (m_d),
        .valid (m_valid),
        .q     (m_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic          s_valid;
            logic          s_load;
            logic          s_drop;
            logic [PW-1:0] s_q;

            pipe_entry #(.W(PW)) u_skid (
                .clk   (clk),
                .rst_n (rst_n),
                .clear (flush_i),
                .load  (s_load),
                .drop  (s_drop),
                .d     (in_pl),
                .valid (s_valid),
                .q     (s_q)
            );

            // S only fills while M is full, so S valid means "both full" and
            // ready_o can be the inverted S flop with no path from ready_i.
            always_comb begin
                m_load = 1'b0;
                m_drop = 1'b0;
                m_d    = in_pl;
                s_load = 1'b0;
                s_drop = 1'b0;
                if (s_valid) begin
                    if (issue) begin
                        m_load = 1'b1;
                        m_d    = s_q;
                        s_drop = 1'b1;
                    end
                end else if (accept && (!m_valid || issue)) begin
                    m_load = 1'b1;
                end else if (accept) begin
                    s_load = 1'b1;
                end else if (issue) begin
                    m_drop = 1'b1;
                end
            end

            assign ready_o = ~s_valid;
            assign held    = m_valid | s_valid;
        end else begin : g_single
            assign ready_o = ready_i | ~m_valid;
            assign m_load  = accept;
            assign m_drop  = issue & ~accept;
            assign m_d     = in_pl;
            assign held    = m_valid;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (flush_i && (held || accept) && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign {m_ctrl, data_o, tag_o} = m_q;
    assign valid_o     = m_valid;
    assign ctrl_o      = m_valid ? m_ctrl : '0;
    assign flush_cnt_o = cnt;

endmodule

// File: tb/tb_ex_pipe_reg.sv
// tb_ex_pipe_reg: drives three ex_pipe_reg instances (SKID=1, SKID=0, SKID=1 with
// a 2-bit flush counter) from shared random/directed stimulus and compares each
// against a FIFO-occupancy reference model.
module tb_ex_pipe_reg;
    import ex_pipe_reg_pkg::*;

    localparam int CW = CTRL_W_DEF;
    localparam int DW = DATA_W_DEF;
    localparam int TW = TAG_W_DEF;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } beat_t;

    logic  clk     = 1'b0;
    logic  rst_n   = 1'b0;
    logic  valid_i = 1'b0;
    logic  ready_i = 1'b0;
    logic  flush_i = 1'b0;
    beat_t bin     = '0;

    logic          ro [3];
    logic          vo [3];
    logic [CW-1:0] co [3];
    logic [DW-1:0] dout [3];
    logic [TW-1:0] to [3];
    logic [7:0]    fc0;
    logic [7:0]    fc1;
    logic [1:0]    fc2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_pipe_reg #(.SKID(1), .CNT_W(8)) dut_skid (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ro[0]),
        .ctrl_i(bin.ctrl), .data_i(bin.data), .tag_i(bin.tag), .flush_i(flush_i),
        .valid_o(vo[0]), .ready_i(ready_i), .ctrl_o(co[0]), .data_o(dout[0]),
        .tag_o(to[0]), .flush_cnt_o(fc0)
    );

    ex_pipe_reg #(.SKID(0), .CNT_W(8)) dut_single (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ro[1]),
        .ctrl_i(bin.ctrl), .data_i(bin.data), .tag_i(bin.tag), .flush_i(flush_i),
        .valid_o(vo[1]), .ready_i(ready_i), .ctrl_o(co[1]), .data_o(dout[1]),
        .tag_o(to[1]), .flush_cnt_o(fc1)
    );

    ex_pipe_reg #(.SKID(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ro[2]),
        .ctrl_i(bin.ctrl), .data_i(bin.data), .tag_i(bin.tag), .flush_i(flush_i),
        .valid_o(vo[2]), .ready_i(ready_i), .ctrl_o(co[2]), .data_o(dout[2]),
        .tag_o(to[2]), .flush_cnt_o(fc2)
    );

    // Reference model: each register is a FIFO of capacity 1 or 2. "last_m" is the
    // most recent beat that reached the head, which is what the outputs show
    // once the register drains; flush and reset zero it.
    beat_t ent [3][2];
    int    occ [3];
    beat_t last_m [3];
    int    fcnt [3];

    function automatic bit is_skid(int k);
        return k != 1;
    endfunction

    function automatic int cnt_max(int k);
        return (k == 2) ? 3 : 255;
    endfunction

    function automatic logic [7:0] get_fc(int k);
        case (k)
            0:       return fc0;
            1:       return fc1;
            default: return {6'd0, fc2};
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            occ[k]    = 0;
            last_m[k] = '0;
            fcnt[k]   = 0;
            ent[k][0] = '0;
            ent[k][1] = '0;
        end
    endtask

    function automatic beat_t mk_beat(int t);
        beat_t b;
        b.ctrl = CW'($urandom);
        b.data = {$urandom, $urandom, $urandom};
        b.tag  = TW'(t);
        return b;
    endfunction

    // One clock: drive at the falling edge, check outputs, advance the model at
    // the rising edge.
    task automatic step(input logic v, input logic r, input logic f, input beat_t b);
        bit    acc [3];
        bit    iss [3];
        bit    e_ready;
        beat_t head;
        @(negedge clk);
        valid_i = v;
        ready_i = r;
        flush_i = f;
        bin     = b;
        #1;
        for (int k = 0; k < 3; k++) begin
            head    = (occ[k] > 0) ? ent[k][0] : last_m[k];
            e_ready = is_skid(k) ? (occ[k] < 2) : (r || occ[k] == 0);
            check_eq($sformatf("ready_o[%0d]", k), 128'(ro[k]), 128'(e_ready));
            check_eq($sformatf("valid_o[%0d]", k), 128'(vo[k]), 128'(occ[k] > 0));
            check_eq($sformatf("ctrl_o[%0d]", k), 128'(co[k]), (occ[k] > 0) ? 128'(head.ctrl) : 128'(0));
            check_eq($sformatf("data_o[%0d]", k), 128'(dout[k]), 128'(head.data));
            check_eq($sformatf("tag_o[%0d]", k), 128'(to[k]), 128'(head.tag));
            check_eq($sformatf("flush_cnt[%0d]", k), 128'(get_fc(k)), 128'(fcnt[k]));
            acc[k] = v && e_ready;
            iss[k] = (occ[k] > 0) && r;
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (f) begin
                if ((occ[k] > 0 || acc[k]) && fcnt[k] < cnt_max(k)) fcnt[k]++;
                occ[k]    = 0;
                last_m[k] = '0;
            end else begin
                if (iss[k]) begin
                    ent[k][0] = ent[k][1];
                    occ[k]--;
                end
                if (acc[k]) begin
                    ent[k][occ[k]] = b;
                    occ[k]++;
                end
                if (occ[k] > 0) last_m[k] = ent[k][0];
            end
        end
    endtask

    initial begin
        beat_t a, bb, c, d;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("rst_valid[%0d]", k), 128'(vo[k]), 128'(0));
            check_eq($sformatf("rst_ctrl[%0d]", k), 128'(co[k]), 128'(0));
            check_eq($sformatf("rst_ready[%0d]", k), 128'(ro[k]), 128'(1));
            check_eq($sformatf("rst_cnt[%0d]", k), 128'(get_fc(k)), 128'(0));
        end

        // Streaming, tags 1..8.
        for (int t = 1; t <= 8; t++) step(1'b1, 1'b1, 1'b0, mk_beat(t));
        repeat (3) step(1'b0, 1'b1, 1'b0, mk_beat(0));

        // Backpressure A, B, C then release.
        a  = mk_beat(10);
        bb = mk_beat(11);
        c  = mk_beat(12);
        step(1'b1, 1'b0, 1'b0, a);
        step(1'b1, 1'b0, 1'b0, bb);
        step(1'b1, 1'b0, 1'b0, c);
        step(1'b1, 1'b0, 1'b0, c);
        step(1'b1, 1'b1, 1'b0, c);
        step(1'b1, 1'b1, 1'b0, c);
        repeat (4) step(1'b0, 1'b1, 1'b0, mk_beat(0));

        // Flush with both entries full plus an incoming beat, then an empty flush.
        d = mk_beat(13);
        step(1'b1, 1'b0, 1'b0, a);
        step(1'b1, 1'b0, 1'b0, bb);
        step(1'b1, 1'b0, 1'b1, d);
        step(1'b0, 1'b0, 1'b1, d);
        step(1'b0, 1'b1, 1'b0, d);
        check_eq("flush_once", 128'(fc0), 128'(1));

        // Saturation of the 2-bit counter.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, mk_beat(20 + i));
        step(1'b0, 1'b0, 1'b0, mk_beat(0));
        check_eq("sat_cnt", 128'(fc2), 128'(3));

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step(1'(($urandom % 10) < 7), 1'(($urandom % 10) < 6),
                 1'(($urandom % 20) == 0), mk_beat(int'($urandom % 32768)));
        end

        // Asynchronous reset between edges while a beat is held.
        step(1'b1, 1'b0, 1'b0, mk_beat(30));
        @(negedge clk);
        valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("arst_valid[%0d]", k), 128'(vo[k]), 128'(0));
            check_eq($sformatf("arst_ctrl[%0d]", k), 128'(co[k]), 128'(0));
            check_eq($sformatf("arst_data[%0d]", k), 128'(dout[k]), 128'(0));
            check_eq($sformatf("arst_tag[%0d]", k), 128'(to[k]), 128'(0));
            check_eq($sformatf("arst_cnt[%0d]", k), 128'(get_fc(k)), 128'(0));
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-entry mode: streaming with ready_i toggling, plus an
        // intra-cycle toggle of ready_i with a beat held.
        for (int t = 1; t <= 8; t++) step(1'b1, 1'(t % 2), 1'b0, mk_beat(t));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, mk_beat(40 + i));
            @(negedge clk);
            valid_i = 1'b0;
            ready_i = 1'b0;
            #1;
            check_eq("comb_ready_lo", 128'(ro[1]), 128'(occ[1] == 0));
            ready_i = 1'b1;
            #1;
            check_eq("comb_ready_hi", 128'(ro[1]), 128'(1));
            ready_i = 1'b0;
            @(posedge clk);
            step(1'b0, 1'b1, 1'b0, mk_beat(0));
            step(1'b0, 1'b1, 1'b0, mk_beat(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
